mcb_port_bram: RTL
==================

# mcb_port_bram

On-chip responder for the Spartan-6 MCB user-port protocol: accepts write and read burst commands plus write data on the same signals an MCB port pair presents, and serves them from block RAM instead of DDR3. It lets the SDRAM FIFO logic and the host-side transfer paths run and be verified without the memory controller, calibration or external DRAM. One instance emulates one write port plus one read port sharing one memory.

## Interface
- DATA_WIDTH, 32, width of the wr_data/rd_data words.
- MEM_ADDR_WIDTH, 12, log2 of memory depth in words (default 4096 x 32 bit).
- CMD_FIFO_LOG, 2, log2 of each command FIFO depth (default 4 entries).

Ports:
- CLK  in  1  single clock for all logic; rising edge.
- reset  in  1  synchronous, active-high.
- wcmd_en, wcmd_instr, wcmd_bl, wcmd_byte_addr  in  1/3/6/30  write command push, instruction, burst length minus 1, byte address.
- wcmd_full, wcmd_empty  out  1/1  write command FIFO status.
- wr_en, wr_data, wr_mask  in  1/DATA_WIDTH/DATA_WIDTH/8  write data push, word, byte mask (1 = byte not written).
- wr_full, wr_empty, wr_count  out  1/1/7  write data FIFO status, word count 0..64.
- wr_underrun, wr_error  out  1/1  write burst starved, push while full.
- rcmd_en, rcmd_instr, rcmd_bl, rcmd_byte_addr  in  1/3/6/30  read command push.
- rcmd_full, rcmd_empty  out  1/1  read command FIFO status.
- rd_en  in  1  pop read data.
- rd_data, rd_full, rd_empty, rd_count  out  DATA_WIDTH/1/1/7  read FIFO head word (first-word-fall-through), status, count 0..64.
- rd_error  out  1  pop while empty.

## Operation
- Command FIFOs: one per direction, depth 2^CMD_FIFO_LOG; push on cmd_en when not full; cmd_en while full is dropped silently. Word address = byte_addr[MEM_ADDR_WIDTH+1:2], upper bits ignored.
- Instructions: 000 write, 001 read (010/011 write/read with auto-precharge, treated identically). Any other instr is popped and discarded without memory access. Write FIFO only accepts write-type instr, read FIFO only read-type; a mismatched instr is discarded.
- Write data FIFO: 64 words; wr_en when not full pushes {wr_data, wr_mask}; wr_en when full drops word, wr_error=1 next cycle for one cycle.
- Engine FSM states IDLE, WRITE, READ.
  - IDLE: if write command pending -> pop, latch addr, remaining=bl+1, go WRITE. Else if read command pending and (64 - rd_count - inflight) >= bl+1 -> pop, go READ. Writes have strict priority over reads (guarantees read-after-write ordering across ports).
  - WRITE: each cycle with write data FIFO non-empty: pop one word, write unmasked bytes to memory at addr, addr+1 mod 2^MEM_ADDR_WIDTH, remaining-1; remaining reaching 0 -> IDLE. Data FIFO empty while remaining>0 -> stall, wr_underrun=1 that cycle.
  - READ: issue one memory read per cycle, addr+1 mod depth; word enters read FIFO the following cycle; after bl+1 issues -> IDLE.
- Read FIFO: 64 words; rd_data valid whenever rd_empty=0; rd_en pops head; rd_en while empty: no change, rd_error=1 next cycle for one cycle. Overflow cannot occur by space check.
- Memory contents are not cleared by reset.

## Timing
- Reset values: all FIFOs empty (wcmd_empty=rcmd_empty=wr_empty=rd_empty=1, full flags 0, counts 0), wr_underrun=wr_error=rd_error=0, FSM IDLE, rd_data 0.
- cmd_en at edge n -> cmd_empty=0 after edge n; FSM pops at edge n+1; first memory write at edge n+2 if data present.
- Write burst of L words with data pre-loaded: L cycles in WRITE, wr_count falls by 1 per cycle.
- Read: first word at rd_empty=0 three cycles after rcmd_en (push, pop/issue, memory latency); then one word per cycle.
- Simultaneous push and pop on a data FIFO: count unchanged; full FIFO accepts push in same cycle as pop only on read FIFO internal side, never on wr_en side (wr_full decides).
- Counts, flags update in the cycle after the push/pop edge. Reset mid-burst: abort immediately, partial burst words already written stay in memory.

## Test plan
- Push 64 words 0..63 at wr_data, write cmd bl=63 addr 0x100; then read cmd bl=63 addr 0x100 -> rd_data 0..63 in order, rd_count peaks 64, no error flags.
- Write cmd bl=7 with only 4 data words -> 4 words written, wr_underrun high each stalled cycle; push 4 more -> burst completes, FSM IDLE.
- 65 wr_en pulses with no command -> wr_full=1 after 64, wr_error one-cycle pulse, wr_count=64.
- rd_en with rd_empty=1 -> rd_error pulse, rd_count stays 0.
- Write bl=3 at word address 4094 (byte 0x3FF8) values A,B,C,D; read back words 4094,4095,0,1 -> A,B,C,D (wrap).
- Assert reset during a 64-word write after 10 words -> all flags reset, next read of those 10 addresses returns written data.

Source files
------------

// File: rtl/mcb_port_bram.sv
// Block-RAM stand-in for one Spartan-6 MCB write/read port pair: per-direction
// command FIFOs, write/read data FIFOs and a burst engine sharing one memory.
module mcb_port_bram #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MEM_ADDR_WIDTH = 12,
    parameter int unsigned CMD_FIFO_LOG   = 2
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    wcmd_en,
    input  logic [2:0]              wcmd_instr,
    input  logic [5:0]              wcmd_bl,
    input  logic [29:0]             wcmd_byte_addr,
    output logic                    wcmd_full,
    output logic                    wcmd_empty,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_mask,
    output logic                    wr_full,
    output logic                    wr_empty,
    output logic [6:0]              wr_count,
    output logic                    wr_underrun,
    output logic                    wr_error,
    input  logic                    rcmd_en,
    input  logic [2:0]              rcmd_instr,
    input  logic [5:0]              rcmd_bl,
    input  logic [29:0]             rcmd_byte_addr,
    output logic                    rcmd_full,
    output logic                    rcmd_empty,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_full,
    output logic                    rd_empty,
    output logic [6:0]              rd_count,
    output logic                    rd_error
);
    localparam int unsigned BW  = DATA_WIDTH / 8;
    localparam int unsigned AW  = MEM_ADDR_WIDTH;
    localparam int unsigned CW  = CMD_FIFO_LOG;
    localparam int unsigned CD  = 1 << CW;
    localparam int unsigned DAW = 6;
    localparam int unsigned DD  = 64;

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    logic [DATA_WIDTH-1:0] mem [2**AW];
    logic [DATA_WIDTH-1:0] mem_q;
    logic                  rd_vld;

    logic [2:0]    wq_instr [CD];
    logic [5:0]    wq_bl    [CD];
    logic [AW-1:0] wq_addr  [CD];
    logic [CW-1:0] wq_wp, wq_rp;
    logic [CW:0]   wq_cnt;
    logic [2:0]    rq_instr [CD];
    logic [5:0]    rq_bl    [CD];
    logic [AW-1:0] rq_addr  [CD];
    logic [CW-1:0] rq_wp, rq_rp;
    logic [CW:0]   rq_cnt;

    logic [DATA_WIDTH-1:0] wd_data_q [DD];
    logic [BW-1:0]         wd_mask_q [DD];
    logic [DAW-1:0]        wd_wp, wd_rp;
    logic [DATA_WIDTH-1:0] rf_data   [DD];
    logic [DAW-1:0]        rf_wp, rf_rp;

    state_t        state;
    logic [AW-1:0] addr;
    logic [6:0]    remaining;

    logic          wq_push, rq_push, wd_push, rf_pop;
    logic          wq_pop, rq_pop, wd_pop, rd_start, rd_issue;
    logic          wq_is_wr, rq_is_rd;
    logic [6:0]    rd_need, rd_space;
    logic [AW-1:0] rd_addr;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{wcmd_byte_addr[29:AW+2], wcmd_byte_addr[1:0],
                                rcmd_byte_addr[29:AW+2], rcmd_byte_addr[1:0]};

    assign wcmd_full   = (wq_cnt == (CW+1)'(CD));
    assign wcmd_empty  = (wq_cnt == '0);
    assign rcmd_full   = (rq_cnt == (CW+1)'(CD));
    assign rcmd_empty  = (rq_cnt == '0);
    assign wr_full     = (wr_count == 7'(DD));
    assign wr_empty    = (wr_count == 7'd0);
    assign rd_full     = (rd_count == 7'(DD));
    assign rd_empty    = (rd_count == 7'd0);
    assign wr_underrun = (state == WRITE) && wr_empty;
    assign rd_data     = rd_empty ? '0 : rf_data[rf_rp];

    assign wq_push = wcmd_en && !wcmd_full;
    assign rq_push = rcmd_en && !rcmd_full;
    assign wd_push = wr_en && !wr_full;
    assign rf_pop  = rd_en && !rd_empty;

    // Engine decode; writes win over reads, reads start only with room reserved for the whole burst
    always_comb begin
        wq_is_wr = wq_instr[wq_rp] inside {3'b000, 3'b010};
        rq_is_rd = rq_instr[rq_rp] inside {3'b001, 3'b011};
        rd_need  = 7'(rq_bl[rq_rp]) + 7'd1;
        rd_space = 7'(DD) - rd_count - 7'(rd_vld);
        wq_pop   = (state == IDLE) && !wcmd_empty;
        rq_pop   = (state == IDLE) && wcmd_empty && !rcmd_empty &&
                   (!rq_is_rd || (rd_space >= rd_need));
        rd_start = rq_pop && rq_is_rd;
        wd_pop   = (state == WRITE) && !wr_empty && !reset;
        rd_issue = rd_start || (state == READ);
        rd_addr  = rd_start ? rq_addr[rq_rp] : addr;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            wq_wp <= '0; wq_rp <= '0; wq_cnt <= '0;
            rq_wp <= '0; rq_rp <= '0; rq_cnt <= '0;
        end else begin
            if (wq_push) begin
                wq_instr[wq_wp] <= wcmd_instr;
                wq_bl[wq_wp]    <= wcmd_bl;
                wq_addr[wq_wp]  <= wcmd_byte_addr[AW+1:2];
                wq_wp           <= wq_wp + CW'(1);
            end
            if (wq_pop) wq_rp <= wq_rp + CW'(1);
            wq_cnt <= wq_cnt + (CW+1)'(wq_push) - (CW+1)'(wq_pop);
            if (rq_push) begin
                rq_instr[rq_wp] <= rcmd_instr;
                rq_bl[rq_wp]    <= rcmd_bl;
                rq_addr[rq_wp]  <= rcmd_byte_addr[AW+1:2];
                rq_wp           <= rq_wp + CW'(1);
            end
            if (rq_pop) rq_rp <= rq_rp + CW'(1);
            rq_cnt <= rq_cnt + (CW+1)'(rq_push) - (CW+1)'(rq_pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            wd_wp <= '0; wd_rp <= '0; wr_count <= '0; wr_error <= 1'b0;
            rf_wp <= '0; rf_rp <= '0; rd_count <= '0; rd_error <= 1'b0;
            rd_vld <= 1'b0;
        end else begin
            if (wd_push) begin
                wd_data_q[wd_wp] <= wr_data;
                wd_mask_q[wd_wp] <= wr_mask;
                wd_wp            <= wd_wp + DAW'(1);
            end
            if (wd_pop) wd_rp <= wd_rp + DAW'(1);
            wr_count <= wr_count + 7'(wd_push) - 7'(wd_pop);
            wr_error <= wr_en && wr_full;
            rd_vld   <= rd_issue;
            if (rd_vld) begin
                rf_data[rf_wp] <= mem_q;
                rf_wp          <= rf_wp + DAW'(1);
            end
            if (rf_pop) rf_rp <= rf_rp + DAW'(1);
            rd_count <= rd_count + 7'(rd_vld) - 7'(rf_pop);
            rd_error <= rd_en && rd_empty;
        end
    end

    // Memory has no reset so a burst cut short by reset keeps what it wrote
    always_ff @(posedge CLK) begin
        if (wd_pop) begin
            for (int b = 0; b < BW; b++) begin
                if (!wd_mask_q[wd_rp][b]) mem[addr][8*b +: 8] <= wd_data_q[wd_rp][8*b +: 8];
            end
        end
        if (rd_issue) mem_q <= mem[rd_addr];
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wq_pop && wq_is_wr) begin
                        addr      <= wq_addr[wq_rp];
                        remaining <= 7'(wq_bl[wq_rp]) + 7'd1;
                        state     <= WRITE;
                    end else if (rd_start) begin
                        addr      <= rq_addr[rq_rp] + AW'(1);
                        remaining <= 7'(rq_bl[rq_rp]);
                        if (rq_bl[rq_rp] != 6'd0) state <= READ;
                    end
                end
                WRITE: begin
                    if (wd_pop) begin
                        addr      <= addr + AW'(1);
                        remaining <= remaining - 7'd1;
                        if (remaining == 7'd1) state <= IDLE;
                    end
                end
                READ: begin
                    addr      <= addr + AW'(1);
                    remaining <= remaining - 7'd1;
                    if (remaining == 7'd1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
